// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and helpers for the instruction fetch stage.
//   XLEN / ILEN     address and instruction widths
//   fetch_state_e   fetch FSM states
//   fetch_entry_t   {pc, data} pair held in the instruction buffer
//   next_word_pc    sequential fetch address (wraps at 2^32)
package ifetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] data;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_word_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: small circular FIFO used both as the decode-side instruction
// buffer and as the queue of PCs for requests still in flight to imem.
//   clk, rst_n   clock, synchronous active-low reset
//   clear        drop all entries (takes priority over push/pop)
//   push, wdata  write an entry
//   pop          remove the head entry
//   head         entry at the head (undefined when empty)
//   count        number of stored entries
//   full, empty  status flags
// A push is accepted while full as long as a pop happens in the same cycle.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type T = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         push,
  input  T                             wdata,
  input  logic                         pop,
  output T                             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch stage. Owns the fetch PC, issues in-order word requests
// to instruction memory, tracks the PC of every in-flight request and buffers
// returned words for decode. Redirects replace the fetch PC and flush all
// younger work; responses for requests issued before a redirect are dropped.
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   redirect_valid, redirect_pc      new fetch target from next-PC logic
//   imem_req_valid/ready/addr        request channel to imem
//   imem_rsp_valid/data              in-order response channel (no backpressure)
//   inst_valid/ready, inst_data/pc   buffer head towards decode
//   misalign_trap                    only when IFETCH_MISALIGN_TRAP_EN is defined
//
// Build option IFETCH_MISALIGN_TRAP_EN: a redirect to a non-word-aligned target
// parks the unit in HALT with misalign_trap set until an aligned redirect.
// Without it the low two target bits are ignored.
//
// state | meaning
// BOOT  | first cycle after reset, no requests
// RUN   | normal fetch, requests limited by buffer credits
// FLUSH | waiting for stale in-flight responses to drain, all dropped
// HALT  | misaligned redirect taken, idle until an aligned redirect
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int USE_W = CNT_W + 1;

  fetch_state_e     state;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  redir_tgt;
  logic             redir_bad;

  fetch_entry_t     buf_head;
  fetch_entry_t     buf_wdata;
  logic [CNT_W-1:0] buf_count;
  logic             buf_full;
  logic             buf_empty;
  logic             buf_push;

  logic [XLEN-1:0]  pcq_head;
  logic [CNT_W-1:0] pcq_count;
  logic             pcq_full;
  logic             pcq_empty;

  logic             req_fire;
  logic             rsp_take;
  logic             inst_fire;
  logic [USE_W-1:0] used;
  logic [CNT_W-1:0] inflight_nxt;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign redir_tgt = redirect_pc;
  assign redir_bad = (redirect_pc[1:0] != 2'b00);
`else
  assign redir_tgt = redirect_pc & ~XLEN'(3);
  assign redir_bad = 1'b0;
`endif

  assign inst_fire = !buf_empty && inst_ready;

  // A slot being handed to decode this cycle can be re-used by a new request
  // right away; this keeps a single-cycle imem streaming at one word per cycle.
  assign used = USE_W'(pcq_count) + USE_W'(buf_count) - USE_W'(inst_fire);

  assign imem_req_valid = (state == RUN) && (used < USE_W'(BUF_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready && !pcq_full;

  // With nothing outstanding a response can only be a leftover from before
  // reset, so it is ignored.
  assign rsp_take = imem_rsp_valid && !pcq_empty;

  assign inflight_nxt = pcq_count + CNT_W'(req_fire) - CNT_W'(rsp_take);

  assign buf_push  = rsp_take && (state == RUN) && !redirect_valid
                     && (!buf_full || inst_fire);
  assign buf_wdata = '{pc: pcq_head, data: imem_rsp_data};

  assign inst_valid = !buf_empty;
  assign inst_data  = buf_empty ? '0 : buf_head.data;
  assign inst_pc    = buf_empty ? '0 : buf_head.pc;

  ifetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .T     (logic [XLEN-1:0])
  ) u_pcq (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .push  (req_fire),
    .wdata (fetch_pc),
    .pop   (rsp_take),
    .head  (pcq_head),
    .count (pcq_count),
    .full  (pcq_full),
    .empty (pcq_empty)
  );

  ifetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .T     (fetch_entry_t)
  ) u_ibuf (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (redirect_valid),
    .push  (buf_push),
    .wdata (buf_wdata),
    .pop   (inst_fire),
    .head  (buf_head),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
`endif
    end else if (redirect_valid) begin
      fetch_pc <= redir_tgt;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misalign_trap <= redir_bad;
`endif
      if (redir_bad)
        state <= HALT;
      else if (state == FLUSH || inflight_nxt != '0)
        state <= FLUSH;
      else
        state <= RUN;
    end else begin
      if (req_fire) fetch_pc <= next_word_pc(fetch_pc);
      case (state)
        BOOT:    state <= RUN;
        FLUSH:   if (inflight_nxt == '0) state <= RUN;
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  localparam int BD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  ifetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(BD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    .misalign_trap  (misalign_trap)
`endif
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat = 1;
  logic        rdy_cfg = 1'b0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] req_log[$];
  logic [31:0] dlv_pc[$];
  logic [31:0] dlv_data[$];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // One clock cycle: imem model drives its response, handshakes are sampled
  // mid-cycle, accepted requests are queued with their due cycle.
  task automatic cycle();
    logic        acc;
    logic [31:0] a;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data_of(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    imem_req_ready = rdy_cfg;
    #1;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    if (inst_valid && inst_ready) begin
      dlv_pc.push_back(inst_pc);
      dlv_data.push_back(inst_data);
    end
    @(posedge clk);
    if (acc) begin
      req_log.push_back(a);
      pend_addr.push_back(a);
      pend_due.push_back(cyc + lat);
    end
    tests++;
    if (pend_addr.size() > BD) begin
      fails++;
      $display("FAIL inflight_bound: got %0d allowed %0d", pend_addr.size(), BD);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_logs();
    req_log.delete();
    dlv_pc.delete();
    dlv_data.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    inst_ready = 1'b0; rdy_cfg = 1'b0;
    cycle(); cycle();
    pend_addr.delete(); pend_due.delete();
    clear_logs();
  endtask

  task automatic boot();
    do_reset();
    rst_n = 1'b1;
    cycle();
    clear_logs();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
    tests++; if (imem_req_addr !== 32'h0) begin fails++; $display("FAIL rst_req_addr: got %h expected 00000000", imem_req_addr); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rst_inst_valid: got %b expected 0", inst_valid); end
    tests++; if (inst_data !== 32'h0) begin fails++; $display("FAIL rst_inst_data: got %h expected 0", inst_data); end
    tests++; if (inst_pc !== 32'h0) begin fails++; $display("FAIL rst_inst_pc: got %h expected 0", inst_pc); end
`ifdef IFETCH_MISALIGN_TRAP_EN
    tests++; if (misalign_trap !== 1'b0) begin fails++; $display("FAIL rst_trap: got %b expected 0", misalign_trap); end
`endif
    rst_n = 1'b1;
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL boot_req_valid: got %b expected 0", imem_req_valid); end
    cycle();
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      fails++; $display("FAIL run_first_req: got v=%b a=%h expected v=1 a=00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    boot();
    lat = 1; rdy_cfg = 1'b1; inst_ready = 1'b1;
    repeat (12) cycle();
    tests++; if (req_log.size() != 12) begin fails++; $display("FAIL stream_req_count: got %0d expected 12", req_log.size()); end
    for (int i = 0; i < req_log.size() && i < 12; i++) begin
      tests++; if (req_log[i] !== 32'(4 * i)) begin fails++; $display("FAIL stream_req_addr[%0d]: got %h expected %h", i, req_log[i], 32'(4 * i)); end
    end
    tests++; if (dlv_pc.size() != 10) begin fails++; $display("FAIL stream_inst_count: got %0d expected 10", dlv_pc.size()); end
    for (int i = 0; i < dlv_pc.size() && i < 10; i++) begin
      tests++; if (dlv_pc[i] !== 32'(4 * i) || dlv_data[i] !== data_of(32'(4 * i))) begin
        fails++; $display("FAIL stream_inst[%0d]: got pc=%h d=%h expected pc=%h d=%h", i, dlv_pc[i], dlv_data[i], 32'(4 * i), data_of(32'(4 * i)));
      end
    end
  endtask

  task automatic test_backpressure();
    boot();
    lat = 1; rdy_cfg = 1'b1; inst_ready = 1'b0;
    repeat (10) cycle();
    tests++; if (req_log.size() != BD) begin fails++; $display("FAIL bp_req_count: got %0d expected %0d", req_log.size(), BD); end
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
    tests++; if (dlv_pc.size() != 0) begin fails++; $display("FAIL bp_no_delivery: got %0d expected 0", dlv_pc.size()); end
    inst_ready = 1'b1;
    repeat (10) cycle();
    tests++; if (dlv_pc.size() != 10) begin fails++; $display("FAIL bp_inst_count: got %0d expected 10", dlv_pc.size()); end
    for (int i = 0; i < dlv_pc.size() && i < 10; i++) begin
      tests++; if (dlv_pc[i] !== 32'(4 * i) || dlv_data[i] !== data_of(32'(4 * i))) begin
        fails++; $display("FAIL bp_inst[%0d]: got pc=%h d=%h expected pc=%h", i, dlv_pc[i], dlv_data[i], 32'(4 * i));
      end
    end
    for (int i = 0; i < req_log.size(); i++) begin
      tests++; if (req_log[i] !== 32'(4 * i)) begin fails++; $display("FAIL bp_req_addr[%0d]: got %h expected %h", i, req_log[i], 32'(4 * i)); end
    end
  endtask

  task automatic test_redirect_flush();
    boot();
    lat = 3; rdy_cfg = 1'b1; inst_ready = 1'b1;
    cycle(); cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    tests++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h100) begin
      fails++; $display("FAIL flush_state: got v=%b a=%h expected v=0 a=00000100", imem_req_valid, imem_req_addr);
    end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL flush_inst_valid: got %b expected 0", inst_valid); end
    cycle(); cycle();
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      fails++; $display("FAIL flush_resume: got v=%b a=%h expected v=1 a=00000100", imem_req_valid, imem_req_addr);
    end
    repeat (8) cycle();
    tests++; if (req_log.size() < 3 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4 || req_log[2] !== 32'h100) begin
      fails++; $display("FAIL flush_req_seq: got n=%0d expected 0,4,100", req_log.size());
    end
    tests++; if (dlv_pc.size() == 0 || dlv_pc[0] !== 32'h100 || dlv_data[0] !== data_of(32'h100)) begin
      fails++; $display("FAIL flush_first_inst: got n=%0d expected pc=00000100", dlv_pc.size());
    end
  endtask

  task automatic test_redirect_collision();
    boot();
    lat = 1; rdy_cfg = 1'b1; inst_ready = 1'b1;
    repeat (3) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    tests++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      fails++; $display("FAIL coll_after_redirect: got iv=%b rv=%b expected 0 0", inst_valid, imem_req_valid);
    end
    cycle();
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin
      fails++; $display("FAIL coll_resume: got v=%b a=%h expected v=1 a=00000040", imem_req_valid, imem_req_addr);
    end
    repeat (5) cycle();
    tests++; if (dlv_pc.size() < 3 || dlv_pc[0] !== 32'h0 || dlv_pc[1] !== 32'h4 || dlv_pc[2] !== 32'h40) begin
      fails++; $display("FAIL coll_inst_seq: got n=%0d expected 0,4,40", dlv_pc.size());
    end
  endtask

  task automatic test_wrap();
    boot();
    lat = 1; rdy_cfg = 1'b0; inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect_valid = 1'b0; rdy_cfg = 1'b1;
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFF8) begin
      fails++; $display("FAIL wrap_first: got v=%b a=%h expected v=1 a=fffffff8", imem_req_valid, imem_req_addr);
    end
    repeat (6) cycle();
    tests++; if (req_log.size() < 3 || req_log[0] !== 32'hFFFF_FFF8 || req_log[1] !== 32'hFFFF_FFFC || req_log[2] !== 32'h0) begin
      fails++; $display("FAIL wrap_req_seq: got n=%0d expected fffffff8,fffffffc,0", req_log.size());
    end
    tests++; if (dlv_pc.size() < 3 || dlv_pc[0] !== 32'hFFFF_FFF8 || dlv_pc[1] !== 32'hFFFF_FFFC || dlv_pc[2] !== 32'h0) begin
      fails++; $display("FAIL wrap_inst_seq: got n=%0d expected fffffff8,fffffffc,0", dlv_pc.size());
    end
  endtask

  task automatic test_misalign();
    boot();
    lat = 1; rdy_cfg = 1'b0; inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    cycle();
    redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    tests++; if (misalign_trap !== 1'b1 || imem_req_valid !== 1'b0) begin
      fails++; $display("FAIL mis_trap_set: got t=%b v=%b expected t=1 v=0", misalign_trap, imem_req_valid);
    end
    rdy_cfg = 1'b1;
    repeat (3) cycle();
    tests++; if (misalign_trap !== 1'b1 || req_log.size() != 0) begin
      fails++; $display("FAIL mis_trap_hold: got t=%b reqs=%0d expected t=1 reqs=0", misalign_trap, req_log.size());
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cycle();
    redirect_valid = 1'b0;
    tests++; if (misalign_trap !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      fails++; $display("FAIL mis_trap_clear: got t=%b v=%b a=%h expected t=0 v=1 a=00000200", misalign_trap, imem_req_valid, imem_req_addr);
    end
`else
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      fails++; $display("FAIL mis_force_align: got v=%b a=%h expected v=1 a=00000100", imem_req_valid, imem_req_addr);
    end
`endif
  endtask

  task automatic test_reset_mid();
    boot();
    rdy_cfg = 1'b1; inst_ready = 1'b0;
    lat = 2; cycle();
    lat = 6; cycle();
    cycle();
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      fails++; $display("FAIL mid_pre_reset: got v=%b pc=%h expected v=1 pc=0", inst_valid, inst_pc);
    end
    rst_n = 1'b0;
    cycle();
    tests++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
      fails++; $display("FAIL mid_rst_req: got v=%b a=%h expected v=0 a=0", imem_req_valid, imem_req_addr);
    end
    tests++; if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
      fails++; $display("FAIL mid_rst_inst: got v=%b d=%h pc=%h expected 0", inst_valid, inst_data, inst_pc);
    end
    rst_n = 1'b1; rdy_cfg = 1'b0; inst_ready = 1'b1;
    repeat (5) cycle();
    tests++; if (inst_valid !== 1'b0 || dlv_pc.size() != 0) begin
      fails++; $display("FAIL mid_late_rsp: got v=%b n=%0d expected v=0 n=0", inst_valid, dlv_pc.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_collision();
    test_wrap();
    test_misalign();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
